// File: rtl/or1200_except_pkg.sv
// Shared state encoding, exception type codes and vector layout for the
// exception dispatch slice.
package or1200_except_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FETCH    = 2'd3
  } disp_state_t;

  localparam logic [3:0] EXC_NONE     = 4'd0;
  localparam logic [3:0] EXC_RESET    = 4'd1;
  localparam logic [3:0] EXC_BUSERR   = 4'd2;
  localparam logic [3:0] EXC_DPF      = 4'd3;
  localparam logic [3:0] EXC_IPF      = 4'd4;
  localparam logic [3:0] EXC_TICK     = 4'd5;
  localparam logic [3:0] EXC_ALIGN    = 4'd6;
  localparam logic [3:0] EXC_ILLEGAL  = 4'd7;
  localparam logic [3:0] EXC_INT      = 4'd8;
  localparam logic [3:0] EXC_DTLBMISS = 4'd9;
  localparam logic [3:0] EXC_ITLBMISS = 4'd10;
  localparam logic [3:0] EXC_RANGE    = 4'd11;
  localparam logic [3:0] EXC_SYSCALL  = 4'd12;
  localparam logic [3:0] EXC_FP       = 4'd13;
  localparam logic [3:0] EXC_TRAP     = 4'd14;

  localparam int VEC_OFS_SHIFT = 8;

endpackage

// File: rtl/or1200_except_vecgen.sv
// Exception vector address: optional high prefix OR'ed with the type code
// placed at the vector offset.
module or1200_except_vecgen
  import or1200_except_pkg::*;
#(
  parameter logic [31:0] VEC_HI_BASE = 32'hF000_0000
) (
  input  logic [3:0]  exc_type,
  input  logic        eph,
  output logic [31:0] target
);

  always_comb begin
    target = (eph ? VEC_HI_BASE : 32'h0) | ({28'h0, exc_type} << VEC_OFS_SHIFT);
  end

endmodule

// File: rtl/or1200_except_dispatch.sv
// Converts exception requests and rfe into a genpc redirect, then tracks the
// first fetch at the new target. One pending slot buffers requests while busy.
//
//   state    | meaning
//   IDLE     | waiting for a request or a pending exception
//   FLUSH    | counting flush-free cycles before redirecting
//   REDIRECT | redirect_valid/redirect_pc presented until genpc accepts
//   FETCH    | first fetch at target outstanding, timeout running
module or1200_except_dispatch
  import or1200_except_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] VEC_HI_BASE  = 32'hF000_0000,
  parameter int          ACK_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        except_start,
  input  logic [3:0]  except_type,
  input  logic        except_flushpipe,
  input  logic        sr_eph,
  input  logic        rfe,
  input  logic [31:0] epcr,
  input  logic        genpc_freeze,
  input  logic        icpu_ack_i,
  input  logic        icpu_err_i,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        fetch_req,
  output logic        busy,
  output logic        dispatched,
  output logic [3:0]  dispatch_type,
  output logic        fetch_err,
  output logic        pend_ovf
);

  localparam logic [3:0] FLUSH_N = 4'(FLUSH_CYCLES);
  localparam logic [7:0] TMO_N   = 8'(ACK_TIMEOUT);

  disp_state_t state;
  logic [3:0]  flush_cnt;
  logic [7:0]  tmo_cnt;
  logic [7:0]  tmo_inc;
  logic        pend_full;
  logic [3:0]  pend_type;
  logic [31:0] pend_target;
  logic [31:0] vec_target;
  logic        new_exc;
  logic        take_pend;
  logic        to_slot;

  or1200_except_vecgen #(.VEC_HI_BASE(VEC_HI_BASE)) u_vecgen (
    .exc_type (except_type),
    .eph      (sr_eph),
    .target   (vec_target)
  );

  assign new_exc   = except_start && (except_type != EXC_NONE);
  assign take_pend = (state == ST_IDLE) && pend_full;
  // A new request lands in the slot whenever it cannot be accepted directly.
  assign to_slot   = new_exc && ((state != ST_IDLE) || pend_full);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    tmo_inc = (tmo_cnt == 8'hFF) ? tmo_cnt : tmo_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      flush_cnt      <= 4'd0;
      tmo_cnt        <= 8'd0;
      pend_full      <= 1'b0;
      pend_type      <= 4'd0;
      pend_target    <= 32'h0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
      fetch_req      <= 1'b0;
      dispatched     <= 1'b0;
      dispatch_type  <= 4'd0;
      fetch_err      <= 1'b0;
      pend_ovf       <= 1'b0;
    end else begin
      dispatched <= 1'b0;
      fetch_err  <= 1'b0;
      pend_ovf   <= 1'b0;

      if (to_slot) begin
        pend_full   <= 1'b1;
        pend_type   <= except_type;
        pend_target <= vec_target;
        pend_ovf    <= pend_full && !take_pend;
      end else if (take_pend) begin
        pend_full <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (pend_full) begin
            state         <= ST_FLUSH;
            redirect_pc   <= pend_target;
            dispatch_type <= pend_type;
            flush_cnt     <= except_flushpipe ? 4'd0 : 4'd1;
          end else if (new_exc) begin
            state         <= ST_FLUSH;
            redirect_pc   <= vec_target;
            dispatch_type <= except_type;
            flush_cnt     <= except_flushpipe ? 4'd0 : 4'd1;
          end else if (rfe) begin
            state          <= ST_REDIRECT;
            redirect_pc    <= epcr;
            dispatch_type  <= EXC_NONE;
            redirect_valid <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == FLUSH_N) begin
            state          <= ST_REDIRECT;
            redirect_valid <= 1'b1;
          end else if (except_flushpipe) begin
            flush_cnt <= 4'd0;
          end else if (flush_cnt != 4'hF) begin
            flush_cnt <= flush_cnt + 4'd1;
          end
        end
        ST_REDIRECT: begin
          if (!genpc_freeze) begin
            state          <= ST_FETCH;
            redirect_valid <= 1'b0;
            fetch_req      <= 1'b1;
            tmo_cnt        <= 8'd0;
          end
        end
        ST_FETCH: begin
          tmo_cnt <= tmo_inc;
          if (icpu_err_i || (tmo_inc == TMO_N)) begin
            state     <= ST_IDLE;
            fetch_req <= 1'b0;
            fetch_err <= 1'b1;
          end else if (icpu_ack_i) begin
            state      <= ST_IDLE;
            fetch_req  <= 1'b0;
            dispatched <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_or1200_except_dispatch.sv
// Bench for or1200_except_dispatch: directed cases plus randomized
// transactions checked against a timing-window reference model.
module tb_or1200_except_dispatch;

  localparam int          FLUSH_CYCLES = 2;
  localparam logic [31:0] VEC_HI_BASE  = 32'hF000_0000;
  localparam int          ACK_TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        except_start;
  logic [3:0]  except_type;
  logic        except_flushpipe;
  logic        sr_eph;
  logic        rfe;
  logic [31:0] epcr;
  logic        genpc_freeze;
  logic        icpu_ack_i;
  logic        icpu_err_i;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_req;
  logic        busy;
  logic        dispatched;
  logic [3:0]  dispatch_type;
  logic        fetch_err;
  logic        pend_ovf;

  always #5 clk = ~clk;

  or1200_except_dispatch #(
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .VEC_HI_BASE  (VEC_HI_BASE),
    .ACK_TIMEOUT  (ACK_TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .except_start     (except_start),
    .except_type      (except_type),
    .except_flushpipe (except_flushpipe),
    .sr_eph           (sr_eph),
    .rfe              (rfe),
    .epcr             (epcr),
    .genpc_freeze     (genpc_freeze),
    .icpu_ack_i       (icpu_ack_i),
    .icpu_err_i       (icpu_err_i),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .fetch_req        (fetch_req),
    .busy             (busy),
    .dispatched       (dispatched),
    .dispatch_type    (dispatch_type),
    .fetch_err        (fetch_err),
    .pend_ovf         (pend_ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction descriptor; kind 0 = exception, 1 = rfe, 2 = both at once.
  // Outcome 0 = ack, 1 = err, 2 = ack+err, 3 = no response (timeout).
  int          kind;
  logic [3:0]  p_type;
  logic        p_eph;
  logic [31:0] p_epcr;
  int          p_f, p_out, p_a;
  logic [3:0]  fp_bits;
  int          inj_n;
  logic [3:0]  inj_type [3];
  logic        inj_eph  [3];
  int          s_f, s_out, s_a;
  logic [3:0]  last_dtype = 4'd0;

  function automatic logic [31:0] vec_of(input logic [3:0] ty, input logic eph);
    return (eph ? VEC_HI_BASE : 32'h0) + 32'(ty) * 32'd256;
  endfunction

  function automatic bit win(input int t, input int lo, input int hi);
    return (t >= lo) && (t <= hi);
  endfunction

  function automatic bit fp_at(input int c);
    if (c >= 0 && c < 4) return fp_bits[c];
    return 1'b0;
  endfunction

  task automatic drive_quiet();
    except_start     = 1'b0;
    except_type      = 4'($urandom_range(0, 15));
    except_flushpipe = 1'($urandom_range(0, 1));
    sr_eph           = 1'($urandom_range(0, 1));
    rfe              = 1'b0;
    epcr             = $urandom;
    genpc_freeze     = 1'($urandom_range(0, 1));
    icpu_ack_i       = 1'b0;
    icpu_err_i       = 1'b0;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val("idle_flags", 32'({redirect_valid, fetch_req, busy, dispatched, fetch_err, pend_ovf}), 32'h0);
      check_val("idle_dtype", 32'(dispatch_type), 32'(last_dtype));
      drive_quiet();
      if ($urandom_range(0, 2) == 0) begin
        except_start = 1'b1;
        except_type  = 4'd0;
      end
    end
  endtask

  task automatic run_txn();
    int k1, fo1, a1, end1, k2, fo2, a2, end2, t_last, j, nin;
    int inj_cyc [3];
    bit err1, err2, has_sec, e_rv, e_fr, e_busy, e_disp, e_ferr, e_ovf, lows;
    logic [31:0] pc1, pc2;
    logic [3:0]  ty1, ty2, e_dt;

    if (kind == 1) begin
      k1 = 1; pc1 = p_epcr; ty1 = 4'd0;
    end else begin
      j = FLUSH_CYCLES - 1;
      forever begin
        lows = 1'b1;
        for (int c = j - FLUSH_CYCLES + 1; c <= j; c++) if (fp_at(c)) lows = 1'b0;
        if (lows) break;
        j++;
      end
      k1 = j + 2; pc1 = vec_of(p_type, p_eph); ty1 = p_type;
    end
    a1   = (p_out == 3) ? ACK_TIMEOUT - 1 : p_a;
    err1 = (p_out != 0);
    fo1  = k1 + p_f + 1;
    end1 = fo1 + a1 + 1;

    nin = (inj_n < end1 - 1) ? inj_n : end1 - 1;
    for (int i = 0; i < 3; i++) inj_cyc[i] = -10;
    for (int i = 0; i < nin; i++) begin
      int lo;
      lo = (i == 0) ? 1 : inj_cyc[i-1] + 1;
      inj_cyc[i] = $urandom_range(lo, end1 - nin + i);
    end
    has_sec = (nin > 0);
    ty2  = has_sec ? inj_type[nin-1] : 4'd0;
    pc2  = has_sec ? vec_of(inj_type[nin-1], inj_eph[nin-1]) : 32'h0;
    k2   = end1 + FLUSH_CYCLES + 1;
    a2   = (s_out == 3) ? ACK_TIMEOUT - 1 : s_a;
    err2 = (s_out != 0);
    fo2  = k2 + s_f + 1;
    end2 = fo2 + a2 + 1;
    t_last = has_sec ? end2 : end1;

    for (int t = 0; t <= t_last; t++) begin
      @(negedge clk);
      e_rv   = win(t, k1, k1 + p_f) || (has_sec && win(t, k2, k2 + s_f));
      e_fr   = win(t, fo1, fo1 + a1) || (has_sec && win(t, fo2, fo2 + a2));
      e_busy = win(t, 1, end1 - 1) || (has_sec && win(t, end1 + 1, end2 - 1));
      e_disp = (t == end1 && !err1) || (has_sec && t == end2 && !err2);
      e_ferr = (t == end1 && err1) || (has_sec && t == end2 && err2);
      e_ovf  = 1'b0;
      for (int i = 1; i < nin; i++) if (t == inj_cyc[i] + 1) e_ovf = 1'b1;
      e_dt   = (t < 1) ? last_dtype : ((has_sec && t >= end1 + 1) ? ty2 : ty1);
      check_val("flags rv/fr/busy/disp/ferr/ovf",
                32'({redirect_valid, fetch_req, busy, dispatched, fetch_err, pend_ovf}),
                32'({e_rv, e_fr, e_busy, e_disp, e_ferr, e_ovf}));
      check_val("dispatch_type", 32'(dispatch_type), 32'(e_dt));
      if (e_rv) check_val("redirect_pc", redirect_pc, (has_sec && t >= k2) ? pc2 : pc1);

      drive_quiet();
      if (t < k1 - 1) except_flushpipe = fp_at(t);
      else if (has_sec && win(t, end1, k2 - 2)) except_flushpipe = 1'b0;
      if (win(t, k1, k1 + p_f)) genpc_freeze = (t < k1 + p_f);
      if (has_sec && win(t, k2, k2 + s_f)) genpc_freeze = (t < k2 + s_f);
      if (t < fo1 || (has_sec && win(t, end1, fo2 - 1))) begin
        icpu_ack_i = ($urandom_range(0, 4) == 0);
        icpu_err_i = ($urandom_range(0, 6) == 0);
      end
      if (p_out != 3 && t == fo1 + p_a) begin
        icpu_ack_i = (p_out != 1);
        icpu_err_i = (p_out != 0);
      end
      if (has_sec && s_out != 3 && t == fo2 + s_a) begin
        icpu_ack_i = (s_out != 1);
        icpu_err_i = (s_out != 0);
      end
      if (win(t, 1, end1 - 1) || (has_sec && win(t, end1 + 1, end2 - 1))) begin
        rfe = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 5) == 0) begin
          except_start = 1'b1;
          except_type  = 4'd0;
        end
      end
      if (t == t_last && $urandom_range(0, 1) == 0) begin
        except_start = 1'b1;
        except_type  = 4'd0;
      end
      if (t == 0) begin
        sr_eph = p_eph;
        if (kind != 1) begin
          except_start = 1'b1;
          except_type  = p_type;
        end
        if (kind != 0) begin
          rfe  = 1'b1;
          epcr = p_epcr;
        end
      end
      for (int i = 0; i < nin; i++) begin
        if (t == inj_cyc[i]) begin
          except_start = 1'b1;
          except_type  = inj_type[i];
          sr_eph       = inj_eph[i];
        end
      end
    end
    last_dtype = has_sec ? ty2 : ty1;
  endtask

  task automatic set_txn(input int kd, input logic [3:0] ty, input logic eph,
                         input logic [31:0] pc, input int f, input int out, input int a);
    kind = kd; p_type = ty; p_eph = eph; p_epcr = pc;
    p_f = f; p_out = out; p_a = a; fp_bits = 4'h0; inj_n = 0;
    s_f = 0; s_out = 0; s_a = 0;
  endtask

  initial begin
    rst = 1'b1;
    drive_quiet();
    #1 rst = 1'b0;
    #2;
    check_val("reset_flags", 32'({redirect_valid, fetch_req, busy, dispatched, fetch_err, pend_ovf}), 32'h0);
    check_val("reset_pc", redirect_pc, 32'h0);
    check_val("reset_dtype", 32'(dispatch_type), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle_check(3);

    // Illegal instruction, eph=0, ack two cycles into the fetch.
    set_txn(0, 4'h7, 1'b0, 32'h0, 0, 0, 2);
    run_txn();
    // Syscall with eph=1 and three frozen cycles.
    set_txn(0, 4'hC, 1'b1, 32'h0, 3, 0, 0);
    run_txn();
    // rfe goes straight to REDIRECT with epcr.
    set_txn(1, 4'h0, 1'b0, 32'h0000_1234, 0, 0, 1);
    run_txn();
    // Exception and rfe together: the exception wins.
    set_txn(2, 4'h5, 1'b0, 32'h0000_1234, 1, 0, 0);
    run_txn();
    // Two requests while busy: one overflow, the later one dispatched.
    set_txn(0, 4'h3, 1'b0, 32'h0, 1, 0, 3);
    inj_n = 2; inj_type[0] = 4'h2; inj_eph[0] = 1'b0; inj_type[1] = 4'h9; inj_eph[1] = 1'b0;
    run_txn();
    // No response: timeout after ACK_TIMEOUT cycles of fetch_req.
    set_txn(0, 4'hB, 1'b0, 32'h0, 0, 3, 0);
    run_txn();
    // Ack and err together: err wins.
    set_txn(1, 4'h0, 1'b0, 32'hDEAD_BEE0, 0, 2, 4);
    run_txn();
    idle_check(2);

    for (int n = 0; n < 40; n++) begin
      kind    = $urandom_range(0, 3) % 3;
      p_type  = 4'($urandom_range(1, 15));
      p_eph   = 1'($urandom_range(0, 1));
      p_epcr  = $urandom;
      p_f     = $urandom_range(0, 3);
      p_out   = $urandom_range(0, 3);
      p_a     = $urandom_range(0, ACK_TIMEOUT - 2);
      fp_bits = 4'($urandom_range(0, 15));
      inj_n   = $urandom_range(0, 3);
      for (int i = 0; i < 3; i++) begin
        inj_type[i] = 4'($urandom_range(1, 15));
        inj_eph[i]  = 1'($urandom_range(0, 1));
      end
      s_f   = $urandom_range(0, 3);
      s_out = $urandom_range(0, 3);
      s_a   = $urandom_range(0, ACK_TIMEOUT - 2);
      run_txn();
      idle_check($urandom_range(0, 2));
    end

    // Reset while in REDIRECT with a pending exception queued.
    @(negedge clk);
    drive_quiet();
    except_flushpipe = 1'b0; genpc_freeze = 1'b1;
    except_start = 1'b1; except_type = 4'h6; sr_eph = 1'b0;
    @(negedge clk);
    except_start = 1'b1; except_type = 4'hA;
    @(negedge clk);
    except_start = 1'b0;
    @(negedge clk);
    check_val("rst_pre_rv", 32'(redirect_valid), 32'h1);
    check_val("rst_pre_pc", redirect_pc, 32'h0000_0600);
    @(negedge clk);
    check_val("rst_pre_rv_held", 32'(redirect_valid), 32'h1);
    rst = 1'b0;
    #1;
    check_val("rst_rv_drop", 32'(redirect_valid), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_pc", redirect_pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    genpc_freeze = 1'b0;
    last_dtype = 4'd0;
    idle_check(4);

    set_txn(0, 4'hE, 1'b1, 32'h0, 2, 1, 5);
    run_txn();
    idle_check(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/or1200_except_dispatch.md
Name: or1200_except_dispatch

Overview:
- Consumer side of the exception unit's `except_start`/`except_type` interface.
- Turns an exception request, or a return-from-exception (`rfe`), into a fetch redirect: waits out the pipeline flush, presents the vector or EPCR target to genpc, then tracks the first instruction fetch at that target until ack, error or timeout.
- Sits between the exception unit and the genpc/IF stage.

Parameters:
- FLUSH_CYCLES, 2: cycles held in FLUSH after `except_flushpipe` is low; range 1..15.
- VEC_HI_BASE, 32'hF000_0000: vector base used when `sr_eph`=1.
- ACK_TIMEOUT, 16: max cycles in FETCH before `fetch_err`; range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- except_start  in  1  one-cycle exception request.
- except_type  in  4  exception code; 0 = none.
- except_flushpipe  in  1  pipeline flush in progress.
- sr_eph  in  1  exception prefix high.
- rfe  in  1  one-cycle return-from-exception request.
- epcr  in  32  return target for `rfe`.
- genpc_freeze  in  1  genpc cannot accept a redirect this cycle.
- icpu_ack_i  in  1  fetch ack.
- icpu_err_i  in  1  fetch bus error.
- redirect_valid  out  1  redirect presented to genpc.
- redirect_pc  out  32  redirect target.
- fetch_req  out  1  first fetch at target outstanding.
- busy  out  1  state != IDLE.
- dispatched  out  1  one-cycle pulse on successful fetch ack.
- dispatch_type  out  4  type of the current/last dispatch; 0 for `rfe`.
- fetch_err  out  1  one-cycle pulse on `icpu_err_i` or timeout.
- pend_ovf  out  1  one-cycle pulse when the pending slot is overwritten.

Behaviour:
- Reset (`rst`=0, async): state=IDLE; all outputs 0; `redirect_pc`=0; pending slot empty; counters 0.
- Vector calculation: `target = (sr_eph ? VEC_HI_BASE : 0) | {20'h0, type, 8'h00}`. `sr_eph` is sampled in the cycle the request is accepted.
- States: IDLE, FLUSH, REDIRECT, FETCH.
- IDLE:
  - `except_start` with type != 0: latch type and target; go to FLUSH.
  - `except_start` with type == 0: ignored.
  - `rfe` (without `except_start`): latch target = `epcr`, type = 0; go directly to REDIRECT.
  - Both in the same cycle: the exception wins and `rfe` is dropped.
  - A non-empty pending slot is taken before new inputs; pending exceptions enter FLUSH.
- FLUSH:
  - Counter counts only while `except_flushpipe`=0.
  - Go to REDIRECT the cycle after the count reaches FLUSH_CYCLES.
  - `except_flushpipe` reasserting clears the counter.
- REDIRECT:
  - `redirect_valid`=1 and `redirect_pc`=target, held stable while in REDIRECT.
  - Transfer completes in a cycle with `genpc_freeze`=0; go to FETCH next cycle.
  - Minimum latency from `except_start` to the first `redirect_valid`: FLUSH_CYCLES+1 cycles.
- FETCH:
  - `fetch_req`=1; timeout counter runs.
  - `icpu_ack_i`: pulse `dispatched`, return to IDLE.
  - `icpu_err_i`, or timeout counter reaching ACK_TIMEOUT: pulse `fetch_err`, return to IDLE.
  - Ack and err in the same cycle: err wins.
- Pending slot (one entry):
  - `except_start` with type != 0 while `busy` is stored in the slot.
  - If the slot is already full, the new request overwrites it and `pend_ovf` pulses.
  - `rfe` while `busy` is ignored.
- `dispatch_type` updates on entry to FLUSH (exceptions) or REDIRECT (`rfe`) and holds until the next dispatch.
- Counter widths: 4-bit flush counter, 8-bit timeout counter; neither wraps (both saturate).

Decomposition:
- Shared package `or1200_except_pkg`:
  - state enum: IDLE=0, FLUSH=1, REDIRECT=2, FETCH=3.
  - EXC_* 4-bit type codes (RESET=1, BUSERR=2, … SYSCALL=12, FP=13, TRAP=14).
  - vector offset shift constant = 8.
- Sub-module: `or1200_except_vecgen`, combinational: type + eph -> target.

Test Plan:
- Illegal exception, eph=0, no freeze: `except_start`, type=4'h7, flushpipe low; ack 2 cycles after `fetch_req` -> `redirect_valid` with `redirect_pc`=32'h0000_0700 three cycles after start; `dispatched` pulse; `dispatch_type`=7.
- Syscall with eph=1, `genpc_freeze` high 3 cycles -> `redirect_pc`=32'hF000_0C00 held stable 4 cycles; exactly one transfer.
- `rfe` with `epcr`=32'h0000_1234 -> `redirect_valid` next cycle with 32'h0000_1234; `dispatch_type`=0; FLUSH skipped.
- `except_start` (type 5) and `rfe` in the same cycle -> target 32'h500; no rfe redirect ever issued.
- Two `except_start` (types 2, then 9) while busy -> `pend_ovf` pulse once; after the first dispatch, type 9 dispatched at 32'h900.
- FETCH with no ack for 16 cycles -> `fetch_err` pulse, IDLE. Separately, assert `rst` low while in REDIRECT -> `redirect_valid` drops immediately and pending is cleared.
